// File: rtl/rgb_hue_pwm.sv
`timescale 1ns/1ps
// rgb_hue_pwm: N-channel LED PWM engine driven by a shared hue wheel
// (per-channel phase offsets), a shared breathe level, or static duties.
//
// Optional feature macro: GAMMA_EN. When it is defined, a square-law gamma
// is applied ahead of the duty latch.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   en           run enable (IDLE <-> RUN)
//   mode         0 rainbow, 1 breathe, 2/3 static
//   phase_ofs    per-channel hue offset, channel k at [k*(R+3) +: R+3]
//   static_duty  per-channel static duty, channel k at [k*R +: R]
//   pwm_out      registered PWM outputs
//   period_start registered one-cycle pulse on the first clock of a period
module rgb_hue_pwm #(
  parameter int unsigned N_CH        = 3,
  parameter int unsigned R           = 8,
  parameter int unsigned DVSR        = 488,
  parameter int unsigned STEP_CYCLES = 100_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [N_CH*(R+3)-1:0]    phase_ofs,
  input  logic [N_CH*R-1:0]        static_duty,
  output logic [N_CH-1:0]          pwm_out,
  output logic                     period_start
);

  localparam int unsigned HW    = R + 3;
  localparam int unsigned SW    = R + 4;
  localparam int unsigned H_MAX = 6 * (2 ** R);
  localparam int unsigned DMAX  = (2 ** R) - 1;
  localparam int unsigned PW    = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int unsigned TW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic               w_latch;
  logic [PW-1:0]      r_psc;
  logic [PW-1:0]      w_psc_nxt;
  logic [R-1:0]       r_cnt;
  logic [R-1:0]       w_cnt_nxt;
  logic [TW-1:0]      r_step;
  logic [HW-1:0]      r_hue;
  logic [HW-1:0]      w_hue_inc;
  logic [R-1:0]       r_lvl;
  logic               r_dn;
  logic [N_CH*R-1:0]  r_duty;
  logic [N_CH*R-1:0]  w_duty_sel;
  logic [N_CH*R-1:0]  w_duty_nxt;
  logic [N_CH-1:0]    r_pwm;
  logic [N_CH-1:0]    w_pwm_nxt;
  logic               r_ps;
  logic               w_tick;
  logic               w_step_tick;
  logic               w_wrap;

  assign pwm_out      = r_pwm;
  assign period_start = r_ps;

  assign w_tick      = (r_state == S_RUN) && (r_psc == PW'(DVSR - 1));
  assign w_step_tick = (r_state == S_RUN) && (r_step == TW'(STEP_CYCLES - 1));
  assign w_wrap      = w_tick && (r_cnt == R'(DMAX));
  assign w_hue_inc   = r_hue + HW'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state; w_latch marks the cycle whose edge starts a new period
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_nxt = S_RUN;
          w_latch     = 1'b1;
        end
      end
      S_RUN: begin
        if (!en)         w_state_nxt = S_IDLE;
        else if (w_wrap) w_latch     = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Prescaler and PWM counter; both cleared whenever not staying in RUN
  always_comb begin
    w_psc_nxt = '0;
    w_cnt_nxt = '0;
    if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
      w_psc_nxt = w_tick ? '0 : r_psc + PW'(1);
      w_cnt_nxt = w_tick ? r_cnt + R'(1) : r_cnt;
    end
  end

  // Per-channel duty selection (rainbow / breathe / static, optional gamma)
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [HW-1:0] w_ofs_raw;
    logic [HW-1:0] w_ofs;
    logic [SW-1:0] w_sum;
    logic [HW-1:0] w_h;
    logic [2:0]    w_seg;
    logic [R-1:0]  w_f;
    logic [R-1:0]  w_rb;
    logic [R-1:0]  w_sel;

    // Offset < 2*H_MAX and hue+offset < 2*H_MAX, so one subtract each suffices
    assign w_ofs_raw = phase_ofs[k*HW +: HW];
    assign w_ofs     = (w_ofs_raw >= HW'(H_MAX)) ? (w_ofs_raw - HW'(H_MAX)) : w_ofs_raw;
    assign w_sum     = SW'(r_hue) + SW'(w_ofs);
    assign w_h       = (w_sum >= SW'(H_MAX)) ? HW'(w_sum - SW'(H_MAX)) : HW'(w_sum);
    assign w_seg     = w_h[HW-1:R];
    assign w_f       = w_h[R-1:0];

    always_comb begin
      case (w_seg)
        3'd0, 3'd5: w_rb = R'(DMAX);
        3'd1:       w_rb = R'(DMAX) - w_f;
        3'd4:       w_rb = w_f;
        default:    w_rb = '0;
      endcase
      case (mode)
        2'd0:    w_sel = w_rb;
        2'd1:    w_sel = r_lvl;
        default: w_sel = static_duty[k*R +: R];
      endcase
    end

`ifdef GAMMA_EN
    localparam int unsigned GW = 2 * R;
    logic [GW-1:0] w_sq;
    assign w_sq = GW'(w_sel) * GW'(w_sel);
    assign w_duty_sel[k*R +: R] = R'(w_sq >> R);
`else
    assign w_duty_sel[k*R +: R] = w_sel;
`endif
  end

  assign w_duty_nxt = w_latch ? w_duty_sel : r_duty;

  // Output compare uses next-cycle counter/duty so pwm_out stays registered
  always_comb begin
    w_pwm_nxt = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_pwm_nxt[k] = (w_state_nxt == S_RUN) && (w_cnt_nxt < w_duty_nxt[k*R +: R]);
    end
  end

  // Datapath registers: counters, latched duties, outputs, animation state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psc  <= '0;
      r_cnt  <= '0;
      r_step <= '0;
      r_hue  <= '0;
      r_lvl  <= '0;
      r_dn   <= 1'b0;
      r_duty <= '0;
      r_pwm  <= '0;
      r_ps   <= 1'b0;
    end else begin
      r_psc  <= w_psc_nxt;
      r_cnt  <= w_cnt_nxt;
      r_duty <= w_duty_nxt;
      r_pwm  <= w_pwm_nxt;
      r_ps   <= w_latch;
      if (r_state == S_RUN) r_step <= w_step_tick ? '0 : r_step + TW'(1);
      if (w_step_tick) begin
        r_hue <= (w_hue_inc == HW'(H_MAX)) ? '0 : w_hue_inc;
        // Each endpoint is visited once: flip direction on arrival
        if (!r_dn) begin
          r_lvl <= r_lvl + R'(1);
          if (r_lvl == R'(DMAX - 1)) r_dn <= 1'b1;
        end else begin
          r_lvl <= r_lvl - R'(1);
          if (r_lvl == R'(1)) r_dn <= 1'b0;
        end
      end
    end
  end

endmodule
